// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared word size, word-count limit and loader state encodings
package imem_loader_pkg;
  localparam int WORDSIZE    = 32;
  localparam int ROM_COL_MAX = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  function automatic int idx_width(input int max_words);
    return $clog2(max_words) + 1;
  endfunction
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - gathers four accepted bytes into a little-endian word
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_take,
  input  logic [7:0]          i_data,
  output logic                o_word_valid,
  output logic [WORDSIZE-1:0] o_word
);
  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_take) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_shift[7:0]   <= i_data;
        2'd1:    r_shift[15:8]  <= i_data;
        2'd2:    r_shift[23:16] <= i_data;
        default: r_shift        <= r_shift;
      endcase
    end
  end

  // The fourth byte is forwarded combinationally so the word is usable on its handshake cycle.
  assign o_word_valid = i_take && (r_cnt == 2'd3);
  assign o_word       = {i_data, r_shift};
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory writer; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'd0,
  parameter int          MAX_WORDS     = ROM_COL_MAX,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_in_valid,
  input  logic [7:0]          i_in_data,
  output logic                o_in_ready,
  output logic                o_mem_we,
  output logic [31:0]         o_mem_addr,
  output logic [WORDSIZE-1:0] o_mem_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_cpu_hold
);
  localparam int IDX_W = idx_width(MAX_WORDS);

  logic [2:0]          r_state;
  logic [IDX_W-1:0]    r_index;
  logic [IDX_W-1:0]    r_len;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [WORDSIZE-1:0] r_mem_wdata;
  logic                r_done;
  logic                r_err;
  logic                r_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORDSIZE-1:0] r_sum;
`endif

  logic                w_active;
  logic                w_take;
  logic                w_start;
  logic                w_word_valid;
  logic [WORDSIZE-1:0] w_word;
  logic                w_last;

  assign w_active = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_take   = i_in_valid && w_active;
  assign w_start  = i_start && !w_active;
  assign w_last   = ((r_index + IDX_W'(1)) == r_len);

  imem_loader_byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_start),
    .i_take       (w_take),
    .i_data       (i_in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_len       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_hold      <= HOLD_AT_RESET;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state <= S_LEN;
            r_index <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_word_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= w_word;
`endif
            if (w_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
`endif
            end else if (w_word > WORDSIZE'(MAX_WORDS)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
              r_len   <= w_word[IDX_W-1:0];
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= BASE_ADDR + {{(30-IDX_W){1'b0}}, r_index, 2'b00};
            r_mem_wdata <= w_word;
            r_index     <= r_index + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= r_sum + w_word;
            if (w_last) r_state <= S_CHK;
`else
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_word_valid) begin
            if (w_word == r_sum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = w_active;
  assign o_busy      = w_active;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cpu_hold  = r_hold;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int          MAX_W = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_W), .HOLD_AT_RESET(1'b1)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    bit          gaps;
    bit          mid_start;
    bit          exp_done;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && mem_we === 1'b1) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit wr, input int idx);
    wr_t e;
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      if (wr && k == 3) begin
        e.addr = BASE + 32'(4 * idx);
        e.data = w;
        exp_q.push_back(e);
      end
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] words[3];
    logic [31:0] sum;
    int          w_before;
    words[0] = v.w0;
    words[1] = v.w1;
    words[2] = v.w2;
    w_before = n_writes;
    sum      = v.n;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send_word(v.n, v.gaps, 1'b0, 0);
    if (v.n <= MAX_W) begin
      for (int i = 0; i < int'(v.n); i++) begin
        if (v.mid_start && i == 1) pulse_start();
        send_word(words[i], v.gaps, 1'b1, i);
        sum = sum + words[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(sum, v.gaps, 1'b0, 0);
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    check("done", 32'(done), 32'(v.exp_done));
    check("err", 32'(err), 32'(!v.exp_done));
    check("cpu_hold", 32'(cpu_hold), 32'(!v.exp_done));
    check("busy_end", 32'(busy), 32'd0);
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("write_count", 32'(n_writes - w_before), v.exp_done ? v.n : 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 32'd2,  w0: 32'h0000_0013, w1: 32'h0010_0093, w2: 32'h0, gaps: 0, mid_start: 0, exp_done: 1};
    vecs[1] = '{n: 32'd0,  w0: 32'h0,         w1: 32'h0,         w2: 32'h0, gaps: 0, mid_start: 0, exp_done: 1};
    vecs[2] = '{n: 32'(MAX_W + 1), w0: 32'h0, w1: 32'h0,         w2: 32'h0, gaps: 0, mid_start: 0, exp_done: 0};
    vecs[3] = '{n: 32'd2,  w0: 32'h0000_0013, w1: 32'h0010_0093, w2: 32'h0, gaps: 1, mid_start: 1, exp_done: 1};
    vecs[4] = '{n: 32'd3,  w0: 32'hDEAD_BEEF, w1: 32'h0123_4567, w2: 32'hA5A5_5A5A, gaps: 1, mid_start: 0, exp_done: 1};
    vecs[5] = '{n: 32'h0001_0000, w0: 32'h0,  w1: 32'h0,         w2: 32'h0, gaps: 0, mid_start: 0, exp_done: 0};
    vecs[6] = '{n: 32'd1,  w0: 32'hFFFF_FFFF, w1: 32'h0,         w2: 32'h0, gaps: 0, mid_start: 0, exp_done: 1};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_load(vecs[i]);

    // Reset after 1.5 payload words: one write already issued, partial word discarded.
    begin
      int   w_before;
      wr_t  e;
      w_before = n_writes;
      pulse_start();
      send_word(32'd2, 1'b0, 1'b0, 0);
      send_word(32'h0000_0013, 1'b0, 1'b1, 0);
      send_byte(8'h93);
      send_byte(8'h00);
      reset = 1'b1;
      #1;
      check("mid_rst_writes", 32'(n_writes - w_before), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_mem_we", 32'(mem_we), 32'd0);
      check("mid_rst_mem_addr", mem_addr, BASE);
      check("mid_rst_mem_wdata", mem_wdata, 32'd0);
      check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_load(vecs[0]);
      e.addr = 32'd0;
      e.data = 32'd0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      int w_before;
      w_before = n_writes;
      pulse_start();
      send_word(32'd1, 1'b0, 1'b0, 0);
      send_word(32'h0000_0013, 1'b0, 1'b1, 0);
      send_word(32'h0000_0015, 1'b0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("chk_bad_err", 32'(err), 32'd1);
      check("chk_bad_done", 32'(done), 32'd0);
      check("chk_bad_hold", 32'(cpu_hold), 32'd1);
      check("chk_bad_writes", 32'(n_writes - w_before), 32'd1);
    end
`endif

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
